// File: rtl/spart_pkg.sv
// Shared definitions for the board-to-board serial link (receiver and transmitter).
package spart_pkg;

  // Receiver bit-level FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_t;

  localparam int WORD_W           = 24;
  localparam int BYTES_PER_WORD   = 3;
  // 50 MHz system clock at 115200 baud
  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int TIMEOUT_BITS_DEF = 16;

endpackage

// File: rtl/spart_rx_byte.sv
// 8N1 byte receiver: 2-FF input synchroniser, bit-timing FSM, one-cycle
// byte_valid / frame_err strobes that are asserted combinationally in the
// cycle the stop bit is sampled, so the parent can register on that edge.
module spart_rx_byte
  import spart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       byte_valid_o,
  output logic       frame_err_o,
  output rx_state_t  state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);

  logic            sync1_q;
  logic            rxd_s_q;
  rx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;

  // Two-flop synchroniser; resets to the idle (high) line level
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
    end else begin
      sync1_q <= rxd_i;
      rxd_s_q <= sync1_q;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic: bit timer saturates, sampling uses >= compares
  always_comb begin
    state_d      = state_q;
    cnt_d        = (cnt_q >= FULL_M1) ? cnt_q : cnt_q + 1'b1;
    bit_d        = bit_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (!rxd_s_q) state_d = START;
      end
      START: begin
        // Mid start bit: a high sample means the falling edge was a glitch
        if (cnt_q >= HALF_M1) begin
          cnt_d   = '0;
          state_d = rxd_s_q ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q >= FULL_M1) begin
          cnt_d   = '0;
          shift_d = {rxd_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q >= FULL_M1) begin
          cnt_d = '0;
          if (rxd_s_q) begin
            byte_valid_o = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_o = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // Hold off until the line is released so a break cannot retrigger
        cnt_d = '0;
        if (rxd_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_o  = shift_q;
  assign state_o = state_q;

endmodule

// File: rtl/spart_rx_word.sv
// Word receiver: assembles three bytes (first received = MSB) into a 24-bit
// game message, pulses interrupt_board when complete, drops a partial word
// after an idle timeout or a framing error.
module spart_rx_word
  import spart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int TIMEOUT_BITS = TIMEOUT_BITS_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rxd,
  output logic [WORD_W-1:0] rx_data,
  output logic              interrupt_board,
  output logic              frame_err,
  output logic              busy
);

  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW        = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0] TO_M1 = TW'(TO_CYCLES - 1);

  logic [7:0]        rx_byte;
  logic              byte_valid;
  logic              byte_ferr;
  rx_state_t         rx_state;

  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [15:0]       asm_q, asm_d;
  logic [WORD_W-1:0] rx_data_q, rx_data_d;
  logic              irq_q, irq_d;
  logic              ferr_q, ferr_d;
  logic [TW-1:0]     idle_cnt_q, idle_cnt_d;
  logic              timeout;

  spart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx_byte (
    .clk_i        (clk),
    .rst_i        (rst),
    .rxd_i        (rxd),
    .byte_o       (rx_byte),
    .byte_valid_o (byte_valid),
    .frame_err_o  (byte_ferr),
    .state_o      (rx_state)
  );

  // Word assembly, output and idle-timer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx_q <= '0;
      asm_q      <= '0;
      rx_data_q  <= '0;
      irq_q      <= 1'b0;
      ferr_q     <= 1'b0;
      idle_cnt_q <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      rx_data_q  <= rx_data_d;
      irq_q      <= irq_d;
      ferr_q     <= ferr_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  // Slot selection, word completion, timeout and framing-error discard
  always_comb begin
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    rx_data_d  = rx_data_q;
    irq_d      = 1'b0;
    ferr_d     = 1'b0;
    idle_cnt_d = '0;
    timeout    = 1'b0;

    // Idle timer only runs while a partial word is waiting; it also runs in
    // the start-edge cycle, so a simultaneous timeout makes the new byte slot 0
    if (rx_state == IDLE && byte_idx_q != 2'd0) begin
      if (idle_cnt_q >= TO_M1) timeout = 1'b1;
      else                     idle_cnt_d = idle_cnt_q + 1'b1;
    end

    if (timeout) begin
      byte_idx_d = '0;
    end else if (byte_valid) begin
      case (byte_idx_q)
        2'd0: begin
          asm_d[15:8] = rx_byte;
          byte_idx_d  = 2'd1;
        end
        2'd1: begin
          asm_d[7:0] = rx_byte;
          byte_idx_d = 2'd2;
        end
        default: begin
          rx_data_d  = {asm_q, rx_byte};
          irq_d      = 1'b1;
          byte_idx_d = '0;
        end
      endcase
    end else if (byte_ferr) begin
      ferr_d     = 1'b1;
      byte_idx_d = '0;
    end
  end

  assign rx_data         = rx_data_q;
  assign interrupt_board = irq_q;
  assign frame_err       = ferr_q;
  assign busy            = (rx_state != IDLE) || (byte_idx_q != 2'd0);

endmodule

// File: tb/tb_spart_rx_word.sv
// Bench for spart_rx_word: directed scenarios plus a random byte stream,
// checked against a queue-based model of word assembly.
module tb_spart_rx_word;

  localparam int CPB = 8;
  localparam int TOB = 16;

  logic        clk;
  logic        rst;
  logic        rxd;
  logic [23:0] rx_data;
  logic        interrupt_board;
  logic        frame_err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  pend[$];
  logic [23:0] exp_q[$];
  logic [23:0] last_word = '0;
  int          exp_irq = 0;
  int          exp_fe  = 0;

  // Observed events
  logic [23:0] got_q[$];
  int          irq_cnt  = 0;
  int          fe_cnt   = 0;
  int          both_cnt = 0;

  spart_rx_word #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rxd             (rxd),
    .rx_data         (rx_data),
    .interrupt_board (interrupt_board),
    .frame_err       (frame_err),
    .busy            (busy)
  );

  // Clock and safety limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Monitor: record pulses away from the active edge
  always @(negedge clk) begin
    if (!rst) begin
      if (interrupt_board) begin
        got_q.push_back(rx_data);
        irq_cnt++;
      end
      if (frame_err) fe_cnt++;
      if (interrupt_board && frame_err) both_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: bytes with a good stop bit accumulate; every third closes a word
  function automatic void model_byte(input logic [7:0] b, input bit ok);
    if (!ok) begin
      pend.delete();
      exp_fe++;
    end else begin
      pend.push_back(b);
      if (pend.size() == 3) begin
        last_word = {pend[0], pend[1], pend[2]};
        exp_q.push_back(last_word);
        exp_irq++;
        pend.delete();
      end
    end
  endfunction

  function automatic void model_gap(input int bits);
    if (bits > TOB) pend.delete();
  endfunction

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) begin @(posedge clk); #1; end
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (CPB) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ok, input int gap);
    model_byte(b, ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(ok);
    model_gap(gap);
    idle_bits(gap);
  endtask

  // Stand-in for the 24-bit transmitter: MSB byte first, back to back
  task automatic tx_send_word(input logic [23:0] w);
    send_byte(w[23:16], 1'b1, 0);
    send_byte(w[15:8],  1'b1, 0);
    send_byte(w[7:0],   1'b1, 2);
  endtask

  task automatic scenario_check(input string tag);
    idle_bits(2);
    check({tag, "_irq_count"}, irq_cnt, exp_irq);
    check({tag, "_fe_count"}, fe_cnt, exp_fe);
    check({tag, "_overlap"}, both_cnt, 0);
    check({tag, "_rx_data"}, rx_data, last_word);
    check({tag, "_words_left"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_word"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    bit         ok;
    int         gap;

    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0;
    check("reset_rx_data", rx_data, 0);
    check("reset_irq", interrupt_board, 0);
    check("reset_fe", frame_err, 0);
    check("reset_busy", busy, 0);
    idle_bits(2);

    // Basic word
    send_byte(8'hBE, 1'b1, 0);
    send_byte(8'hEF, 1'b1, 0);
    send_byte(8'hDE, 1'b1, 1);
    scenario_check("beefde");
    check("beefde_busy", busy, 0);

    // Start glitch is rejected
    rxd = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    idle_bits(4);
    check("glitch_busy", busy, 0);
    scenario_check("glitch");

    // Framing error discards the partial word
    send_byte(8'h11, 1'b1, 0);
    send_byte(8'h22, 1'b0, 1);
    send_byte(8'h33, 1'b1, 0);
    send_byte(8'h44, 1'b1, 0);
    send_byte(8'h55, 1'b1, 1);
    scenario_check("frame_err");

    // Idle timeout drops a lone byte
    send_byte(8'hAA, 1'b1, 2);
    check("pending_busy", busy, 1);
    idle_bits(TOB + 4);
    model_gap(TOB + 4);
    check("timeout_busy", busy, 0);
    send_byte(8'h12, 1'b1, 0);
    send_byte(8'h34, 1'b1, 0);
    send_byte(8'h56, 1'b1, 1);
    scenario_check("timeout");

    // Reset during the data bits of the second byte
    send_byte(8'h5A, 1'b1, 0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rxd = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pend.delete();
    last_word = '0;
    check("midrst_rx_data", rx_data, 0);
    check("midrst_irq", interrupt_board, 0);
    check("midrst_fe", frame_err, 0);
    check("midrst_busy", busy, 0);
    idle_bits(4);
    send_byte(8'hC0, 1'b1, 0);
    send_byte(8'hFF, 1'b1, 0);
    send_byte(8'hEE, 1'b1, 1);
    scenario_check("c0ffee");

    // Transmitter-style word
    tx_send_word(24'hBEEFDE);
    scenario_check("loopback");

    // Random byte stream with occasional bad stops and long gaps
    for (int i = 0; i < 40; i++) begin
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 7) != 0);
      if (!ok)                            gap = $urandom_range(1, 2);
      else if ($urandom_range(0, 9) == 0) gap = TOB + 4;
      else                                gap = $urandom_range(0, 2);
      send_byte(b, ok, gap);
    end
    idle_bits(TOB + 4);
    model_gap(TOB + 4);
    scenario_check("random");
    check("final_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
